// File: rtl/hdmi_audio_clkgen.sv
// HDMI audio timing: fractional-divider PCM sample strobe, ACR pulse and N/CTS,
// with rate switches deferred to ACR boundaries so the sink never sees a torn period.
module hdmi_audio_clkgen #(
    parameter int unsigned CLK_HZ  = 12288000,
    parameter int unsigned N_32K   = 4096,
    parameter int unsigned CTS_32K = 27000,
    parameter int unsigned N_44K   = 6272,
    parameter int unsigned CTS_44K = 30000,
    parameter int unsigned N_48K   = 6144,
    parameter int unsigned CTS_48K = 27000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rate_sel,
    output logic        sample_en,
    output logic        acr,
    output logic [19:0] pcm_n,
    output logic [19:0] pcm_cts,
    output logic [1:0]  rate_active,
    output logic        rate_change
);

    localparam logic [1:0] RATE_32K = 2'b00;
    localparam logic [1:0] RATE_44K = 2'b01;
    localparam logic [1:0] RATE_48K = 2'b10;

    localparam logic [7:0] P_LAST_32K = 8'(N_32K / 128 - 1);
    localparam logic [7:0] P_LAST_44K = 8'(N_44K / 128 - 1);
    localparam logic [7:0] P_LAST_48K = 8'(N_48K / 128 - 1);

    function automatic logic [31:0] fs_of(input logic [1:0] rate);
        case (rate)
            RATE_32K: fs_of = 32'd32000;
            RATE_44K: fs_of = 32'd44100;
            default:  fs_of = 32'd48000;
        endcase
    endfunction

    function automatic logic [7:0] p_last_of(input logic [1:0] rate);
        case (rate)
            RATE_32K: p_last_of = P_LAST_32K;
            RATE_44K: p_last_of = P_LAST_44K;
            default:  p_last_of = P_LAST_48K;
        endcase
    endfunction

    function automatic logic [19:0] n_of(input logic [1:0] rate);
        case (rate)
            RATE_32K: n_of = 20'(N_32K);
            RATE_44K: n_of = 20'(N_44K);
            default:  n_of = 20'(N_48K);
        endcase
    endfunction

    function automatic logic [19:0] cts_of(input logic [1:0] rate);
        case (rate)
            RATE_32K: cts_of = 20'(CTS_32K);
            RATE_44K: cts_of = 20'(CTS_44K);
            default:  cts_of = 20'(CTS_48K);
        endcase
    endfunction

    logic [31:0] acc;
    logic [7:0]  sample_cnt;
    logic [1:0]  rate_req;
    logic [1:0]  rate_next;

    logic [32:0] acc_sum;
    logic        wrap;
    logic        boundary;
    logic [1:0]  rate_sel_mapped;

    always_comb begin
        acc_sum         = {1'b0, acc} + {1'b0, fs_of(rate_active)};
        wrap            = (acc_sum >= 33'(CLK_HZ));
        boundary        = sample_en && (sample_cnt == p_last_of(rate_active));
        rate_sel_mapped = (rate_sel == 2'b11) ? RATE_48K : rate_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= 32'd0;
            sample_cnt  <= 8'd0;
            sample_en   <= 1'b0;
            acr         <= 1'b0;
            rate_change <= 1'b0;
            rate_req    <= RATE_48K;
            rate_next   <= RATE_48K;
            rate_active <= RATE_48K;
            pcm_n       <= 20'(N_48K);
            pcm_cts     <= 20'(CTS_48K);
        end else begin
            rate_req    <= rate_sel_mapped;
            acr         <= boundary;
            rate_change <= boundary && (rate_req != rate_active);
            if (boundary) begin
                rate_next <= rate_req;
            end

            // New rate lands the cycle after the boundary ACR, so that ACR carries the old N/CTS.
            if (rate_change) begin
                rate_active <= rate_next;
                pcm_n       <= n_of(rate_next);
                pcm_cts     <= cts_of(rate_next);
                acc         <= 32'd0;
                sample_cnt  <= 8'd0;
                sample_en   <= 1'b0;
            end else begin
                acc       <= wrap ? 32'(acc_sum - 33'(CLK_HZ)) : acc_sum[31:0];
                sample_en <= wrap;
                if (sample_en) begin
                    sample_cnt <= boundary ? 8'd0 : sample_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_audio_clkgen.sv
// Scoreboard bench: an arithmetic model predicts sample/ACR/rate-change events per edge;
// a monitor pops and compares them as the DUT emits strobes.
module tb_hdmi_audio_clkgen;

    localparam longint CLK_HZ = 12288000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate_sel = 2'b10;
    logic        sample_en;
    logic        acr;
    logic        rate_change;
    logic [19:0] pcm_n;
    logic [19:0] pcm_cts;
    logic [1:0]  rate_active;

    hdmi_audio_clkgen dut (
        .clk         (clk),
        .reset       (reset),
        .rate_sel    (rate_sel),
        .sample_en   (sample_en),
        .acr         (acr),
        .pcm_n       (pcm_n),
        .pcm_cts     (pcm_cts),
        .rate_active (rate_active),
        .rate_change (rate_change)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cyc;
        logic   s;
        logic   a;
        logic   rc;
    } ev_t;

    ev_t    evq[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     m_changed = 1'b0;
    logic [1:0] m_rate = 2'b10;
    int     m_acr_cnt = 0;
    int     d_acr_cnt = 0;
    int     m_rc_cnt = 0;
    int     d_rc_cnt = 0;

    function automatic longint fs_of(input logic [1:0] r);
        if (r == 2'b00) return 32000;
        if (r == 2'b01) return 44100;
        return 48000;
    endfunction

    function automatic longint n_of(input logic [1:0] r);
        if (r == 2'b00) return 4096;
        if (r == 2'b01) return 6272;
        return 6144;
    endfunction

    function automatic longint cts_of(input logic [1:0] r);
        if (r == 2'b01) return 30000;
        return 27000;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: sample k since a zero point lands on the first edge j with j*FS >= k*CLK.
    initial begin
        logic [1:0] m_req;
        logic [1:0] m_target;
        longint z, samples, acr_at, apply_at, j, fs;
        ev_t ev;
        m_req = 2'b10; m_target = 2'b10;
        z = 0; samples = 0; acr_at = -1; apply_at = -1;
        forever begin
            @(posedge clk);
            cyc++;
            m_changed = 1'b0;
            if (reset) begin
                m_rate = 2'b10; m_req = 2'b10;
                z = cyc; samples = 0; acr_at = -1; apply_at = -1;
                m_changed = 1'b1;
            end else begin
                ev.cyc = cyc; ev.s = 1'b0; ev.a = 1'b0; ev.rc = 1'b0;
                if (apply_at == cyc) begin
                    m_rate = m_target; z = cyc; samples = 0; apply_at = -1;
                    m_changed = 1'b1;
                end else begin
                    j  = cyc - z;
                    fs = fs_of(m_rate);
                    if (j >= 1 && (j * fs) / CLK_HZ != ((j - 1) * fs) / CLK_HZ) begin
                        ev.s = 1'b1;
                        samples++;
                        if (samples % (n_of(m_rate) / 128) == 0) acr_at = cyc + 1;
                    end
                end
                if (acr_at == cyc) begin
                    ev.a = 1'b1;
                    acr_at = -1;
                    m_acr_cnt++;
                    if (m_req != m_rate) begin
                        ev.rc = 1'b1;
                        apply_at = cyc + 1;
                        m_target = m_req;
                        m_rc_cnt++;
                    end
                end
                if (ev.s || ev.a || ev.rc) evq.push_back(ev);
                m_req = (rate_sel == 2'b11) ? 2'b10 : rate_sel;
            end
        end
    end

    // Monitor
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: expected s=%b a=%b rc=%b at cycle %0d, event not observed",
                         evq[0].s, evq[0].a, evq[0].rc, evq[0].cyc);
                void'(evq.pop_front());
            end
            if (acr) d_acr_cnt++;
            if (rate_change) d_rc_cnt++;
            if (sample_en || acr || rate_change) begin
                checks++;
                if (evq.size() == 0 || evq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL spurious_event: got s=%b a=%b rc=%b expected none (cycle %0d)",
                             sample_en, acr, rate_change, cyc);
                end else begin
                    ev = evq.pop_front();
                    if ({sample_en, acr, rate_change} != {ev.s, ev.a, ev.rc}) begin
                        errors++;
                        $display("FAIL event_flags: got s=%b a=%b rc=%b expected s=%b a=%b rc=%b (cycle %0d)",
                                 sample_en, acr, rate_change, ev.s, ev.a, ev.rc, cyc);
                    end
                end
            end
            if (m_changed || acr || rate_change || (cyc % 64) == 0) begin
                check("rate_active", longint'(rate_active), longint'(m_rate));
                check("pcm_n", longint'(pcm_n), n_of(m_rate));
                check("pcm_cts", longint'(pcm_cts), cts_of(m_rate));
            end
        end
    end

    task automatic run(input logic [1:0] sel, input int unsigned n);
        @(negedge clk);
        rate_sel = sel;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rate_sel = 2'b10;
        repeat (3) @(negedge clk);
        check("reset_sample_en", longint'(sample_en), 0);
        check("reset_acr", longint'(acr), 0);
        check("reset_rate_change", longint'(rate_change), 0);
        check("reset_rate_active", longint'(rate_active), 2);
        check("reset_pcm_n", longint'(pcm_n), 6144);
        check("reset_pcm_cts", longint'(pcm_cts), 27000);
        reset = 1'b0;

        run(2'b10, 13000 + $urandom_range(0, 200));
        run(2'b11, 12000);
        run(2'b10, 200);
        run(2'b00, $urandom_range(50, 500));
        run(2'b10, 1000);
        run(2'b00, 16000 + $urandom_range(0, 500));

        // Reset mid-period at 32k
        @(negedge clk);
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("midreset_rate_active", longint'(rate_active), 2);
        check("midreset_pcm_n", longint'(pcm_n), 6144);
        check("midreset_acr", longint'(acr), 0);
        reset = 1'b0;

        run(2'b00, 14000);
        run(2'b01, 26000);
        for (int i = 0; i < 4; i++) begin
            run(2'($urandom_range(0, 3)), $urandom_range(200, 2000));
        end
        repeat (4) @(negedge clk);

        check("acr_count", longint'(d_acr_cnt), longint'(m_acr_cnt));
        check("rate_change_count", longint'(d_rc_cnt), longint'(m_rc_cnt));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
